multicast_fork_ctrl: RTL and testbench

Per-input multicast fork controller for the router's west and north input paths. It pops one flit at a time from a show-ahead input FIFO and drives per-output requests from the flit's route label (E, S, L) into the output-port round-robin arbiters. It retires each destination as its grant arrives and pops the next flit only when every destination has been served, so a multicast flit is never partially lost.

---
 rtl/multicast_fork_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicast_fork_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_fork_ctrl.sv
// multicast_fork_ctrl
// Per-input multicast fork controller. Pops one flit at a time from a
// show-ahead FIFO, requests every output port named in the route label
// {E,S,L}, retires each destination as its grant arrives, and pops the
// next flit only once all destinations have been served.
// Optional stuck-flit watchdog: define MC_TIMEOUT_EN.
module multicast_fork_ctrl #(
    parameter int DATASIZE = 30,
    parameter int TIMEOUT  = 16
) (
    input  logic                ma_clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    input  logic [DATASIZE-1:0] fifo_data,
    input  logic [4:0]          fifo_label,
    output logic                fifo_rd,
    input  logic                E_grant,
    input  logic                S_grant,
    input  logic                L_grant,
    output logic                E_req,
    output logic                S_req,
    output logic                L_req,
    output logic [DATASIZE-1:0] data_out,
    output logic [2:0]          pending,
    output logic                busy,
    output logic                flit_done,
    output logic                drop,
    output logic                timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        FORK = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          eg;
    logic [2:0]          pending_next;
    logic [DATASIZE-1:0] data_next;
    logic                last;
    logic                drop_next;
    logic                timeout_hit;
    logic                label_unused;

    // Only the low three label bits carry routing information.
    assign label_unused = ^fifo_label[4:3];

    // Grant qualification, last-destination detection, pop strobe and requests.
    // The pop is held off while reset is asserted so a flit is never
    // removed from the FIFO without being captured.
    always_comb begin
        eg      = {E_grant, S_grant, L_grant} & pending;
        last    = (state == FORK) && ((pending & ~eg) == 3'b000) && (eg != 3'b000);
        fifo_rd = rst_n && !fifo_empty && ((state == IDLE) || last);
        busy    = (state == FORK);
        {E_req, S_req, L_req} = busy ? pending : 3'b000;
    end

`ifdef MC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_count;
    logic [7:0] wd_count_next;

    // Watchdog: counts consecutive FORK cycles without any effective grant.
    // A completing grant (last) always carries eg!=0, so it wins over expiry.
    always_comb begin
        wd_count_next = wd_count;
        timeout_hit   = 1'b0;
        if (fifo_rd || (eg != 3'b000)) begin
            wd_count_next = 8'd0;
        end else if (state == FORK) begin
            if (wd_count == TIMEOUT_LAST) begin
                timeout_hit   = 1'b1;
                wd_count_next = 8'd0;
            end else begin
                wd_count_next = wd_count + 8'd1;
            end
        end
    end

    // Watchdog counter and abandon pulse registers.
    always_ff @(posedge ma_clk) begin
        if (!rst_n) begin
            wd_count    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            wd_count    <= wd_count_next;
            timeout_err <= timeout_hit;
        end
    end
`else
    logic timeout_unused;

    // Without the watchdog a stuck flit simply waits for its grants.
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    // Next-state, pending-mask and held-flit update.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        data_next    = data_out;
        drop_next    = 1'b0;
        if (fifo_rd) begin
            data_next    = fifo_data;
            pending_next = fifo_label[2:0];
            if (fifo_label[2:0] == 3'b000) begin
                drop_next  = 1'b1;
                state_next = IDLE;
            end else begin
                state_next = FORK;
            end
        end else if (last) begin
            pending_next = 3'b000;
            state_next   = IDLE;
        end else if (timeout_hit) begin
            pending_next = 3'b000;
            state_next   = IDLE;
        end else if (state == FORK) begin
            pending_next = pending & ~eg;
        end
    end

    // FSM state register.
    always_ff @(posedge ma_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Held flit, pending mask and completion/drop pulse registers.
    always_ff @(posedge ma_clk) begin
        if (!rst_n) begin
            pending   <= 3'b000;
            data_out  <= '0;
            flit_done <= 1'b0;
            drop      <= 1'b0;
        end else begin
            pending   <= pending_next;
            data_out  <= data_next;
            flit_done <= last;
            drop      <= drop_next;
        end
    end

endmodule

// File: tb/tb_multicast_fork_ctrl.sv
// tb_multicast_fork_ctrl
// Directed scoreboard bench for multicast_fork_ctrl. Pulse outputs
// (flit_done/drop/timeout_err) are checked by a monitor against a queue
// of expected events; per-cycle outputs are checked against hand values.
// Define MC_TIMEOUT_EN to exercise the watchdog build.
`timescale 1ns/1ps
module tb_multicast_fork_ctrl;

    localparam logic [2:0] EV_DONE = 3'b100;
    localparam logic [2:0] EV_DROP = 3'b010;
    localparam logic [2:0] EV_TO   = 3'b001;

    logic        ma_clk;
    logic        rst_n;
    logic        fifo_empty;
    logic [29:0] fifo_data;
    logic [4:0]  fifo_label;
    logic        fifo_rd;
    logic        E_grant, S_grant, L_grant;
    logic        E_req, S_req, L_req;
    logic [29:0] data_out;
    logic [2:0]  pending;
    logic        busy, flit_done, drop, timeout_err;

    logic [34:0] fifo_q[$];
    logic [2:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;

    logic [2:0]  t2_grant [5];
    logic [2:0]  t2_pend  [5];
    logic [2:0]  t3_grant [3];
    logic        t3_rd    [3];

    multicast_fork_ctrl #(.DATASIZE(30), .TIMEOUT(16)) dut (
        .ma_clk      (ma_clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_label  (fifo_label),
        .fifo_rd     (fifo_rd),
        .E_grant     (E_grant),
        .S_grant     (S_grant),
        .L_grant     (L_grant),
        .E_req       (E_req),
        .S_req       (S_req),
        .L_req       (L_req),
        .data_out    (data_out),
        .pending     (pending),
        .busy        (busy),
        .flit_done   (flit_done),
        .drop        (drop),
        .timeout_err (timeout_err)
    );

    // Free-running clock.
    initial begin
        ma_clk = 1'b0;
        forever #5 ma_clk = ~ma_clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic refreshFifo();
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            fifo_label = fifo_q[0][34:30];
            fifo_data  = fifo_q[0][29:0];
        end else begin
            fifo_label = 5'd0;
            fifo_data  = 30'd0;
        end
    endtask

    task automatic pushFlit(input logic [4:0] label, input logic [29:0] data);
        fifo_q.push_back({label, data});
        refreshFifo();
    endtask

    task automatic applyStimulus(input logic [2:0] grants);
        {E_grant, S_grant, L_grant} = grants;
    endtask

    // Called at the sampling (negedge) phase; advances to just after the
    // next active edge and pops the FIFO model if the DUT strobed fifo_rd.
    task automatic nextCycle();
        logic        rd;
        logic [34:0] tmp;
        rd = fifo_rd;
        @(posedge ma_clk);
        #1;
        if (rd && fifo_q.size() != 0) begin
            tmp = fifo_q.pop_front();
            pops++;
        end
        applyStimulus(3'b000);
        refreshFifo();
    endtask

    // Monitor: every pulse on the event outputs is matched against the queue.
    always @(negedge ma_clk) begin
        if ({flit_done, drop, timeout_err} != 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got %b expected none",
                         {flit_done, drop, timeout_err});
            end else begin
                checkOutput("event", {29'd0, flit_done, drop, timeout_err}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        t2_grant = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b010};
        t2_pend  = '{3'b111, 3'b011, 3'b011, 3'b010, 3'b010};
        t3_grant = '{3'b001, 3'b100, 3'b010};
        t3_rd    = '{1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        applyStimulus(3'b000);
        refreshFifo();
        @(posedge ma_clk); #1;
        @(posedge ma_clk); #1;

        // Reset state
        @(negedge ma_clk);
        checkOutput("rst_pending", pending, 3'b000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_reqs", {E_req, S_req, L_req}, 3'b000);
        checkOutput("rst_data", data_out, 30'd0);
        checkOutput("rst_pulses", {flit_done, drop, timeout_err}, 3'b000);
        nextCycle();
        rst_n = 1'b1;

        // T1: unicast E, granted on first request cycle
        pushFlit(5'b00100, 30'h1234);
        exp_q.push_back(EV_DONE);
        @(negedge ma_clk);
        checkOutput("t1_rd_c0", fifo_rd, 1'b1);
        nextCycle();
        applyStimulus(3'b100);
        @(negedge ma_clk);
        checkOutput("t1_req_c1", {E_req, S_req, L_req}, 3'b100);
        checkOutput("t1_data_c1", data_out, 30'h1234);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t1_pending_c2", pending, 3'b000);
        checkOutput("t1_busy_c2", busy, 1'b0);

        // T2: multicast E,S,L served on separate cycles
        nextCycle();
        pushFlit(5'b00111, 30'h1234);
        exp_q.push_back(EV_DONE);
        @(negedge ma_clk);
        checkOutput("t2_rd_c0", fifo_rd, 1'b1);
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            applyStimulus(t2_grant[c]);
            @(negedge ma_clk);
            checkOutput($sformatf("t2_pending_c%0d", c + 1), pending, t2_pend[c]);
            checkOutput($sformatf("t2_data_c%0d", c + 1), data_out, 30'h1234);
            checkOutput($sformatf("t2_rd_c%0d", c + 1), fifo_rd, 1'b0);
        end
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t2_pending_end", pending, 3'b000);
        checkOutput("t2_busy_end", busy, 1'b0);

        // T3: three unicast flits back to back
        nextCycle();
        pushFlit(5'b00001, 30'h1);
        pushFlit(5'b00100, 30'h2);
        pushFlit(5'b00010, 30'h3);
        repeat (3) exp_q.push_back(EV_DONE);
        @(negedge ma_clk);
        checkOutput("t3_rd_c0", fifo_rd, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(t3_grant[i]);
            @(negedge ma_clk);
            checkOutput($sformatf("t3_req_c%0d", i + 1), {E_req, S_req, L_req}, t3_grant[i]);
            checkOutput($sformatf("t3_data_c%0d", i + 1), data_out, 30'(i + 1));
            checkOutput($sformatf("t3_rd_c%0d", i + 1), fifo_rd, t3_rd[i]);
        end
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t3_busy_end", busy, 1'b0);

        // T4: label with no destinations is dropped; stray grant ignored
        nextCycle();
        pushFlit(5'b11000, 30'hABC);
        exp_q.push_back(EV_DROP);
        @(negedge ma_clk);
        checkOutput("t4_rd_c0", fifo_rd, 1'b1);
        nextCycle();
        applyStimulus(3'b010);
        @(negedge ma_clk);
        checkOutput("t4_busy_c1", busy, 1'b0);
        checkOutput("t4_reqs_c1", {E_req, S_req, L_req}, 3'b000);
        checkOutput("t4_data_c1", data_out, 30'hABC);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t4_busy_c2", busy, 1'b0);
        checkOutput("t4_pending_c2", pending, 3'b000);

        // T5: reset while a request is outstanding; flit reloaded afterwards
        nextCycle();
        pushFlit(5'b00010, 30'h55);
        exp_q.push_back(EV_DONE);
        @(negedge ma_clk);
        checkOutput("t5_rd_c0", fifo_rd, 1'b1);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t5_req_c1", {E_req, S_req, L_req}, 3'b010);
        nextCycle();
        rst_n = 1'b0;
        pushFlit(5'b00010, 30'h55);
        @(negedge ma_clk);
        checkOutput("t5_rd_in_reset", fifo_rd, 1'b0);
        nextCycle();
        rst_n = 1'b1;
        @(negedge ma_clk);
        checkOutput("t5_pending_after_rst", pending, 3'b000);
        checkOutput("t5_reqs_after_rst", {E_req, S_req, L_req}, 3'b000);
        checkOutput("t5_data_after_rst", data_out, 30'd0);
        checkOutput("t5_busy_after_rst", busy, 1'b0);
        checkOutput("t5_rd_after_rst", fifo_rd, 1'b1);
        nextCycle();
        applyStimulus(3'b010);
        @(negedge ma_clk);
        checkOutput("t5_req_reload", {E_req, S_req, L_req}, 3'b010);
        checkOutput("t5_data_reload", data_out, 30'h55);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t5_busy_end", busy, 1'b0);

        // T6: stuck flit, watchdog build abandons it, default build waits
        nextCycle();
        pushFlit(5'b00100, 30'h77);
`ifdef MC_TIMEOUT_EN
        exp_q.push_back(EV_TO);
        exp_q.push_back(EV_DONE);
        @(negedge ma_clk);
        checkOutput("t6_rd_c0", fifo_rd, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            nextCycle();
            if (c == 10) pushFlit(5'b00001, 30'h88);
            @(negedge ma_clk);
            if (c == 1 || c == 15) checkOutput($sformatf("t6_busy_c%0d", c), busy, 1'b1);
            if (c == 16) begin
                checkOutput("t6_rd_c16", fifo_rd, 1'b0);
                checkOutput("t6_req_c16", {E_req, S_req, L_req}, 3'b100);
                checkOutput("t6_to_c16", timeout_err, 1'b0);
            end
        end
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t6_to_c17", timeout_err, 1'b1);
        checkOutput("t6_busy_c17", busy, 1'b0);
        checkOutput("t6_pending_c17", pending, 3'b000);
        checkOutput("t6_rd_c17", fifo_rd, 1'b1);
        nextCycle();
        applyStimulus(3'b001);
        @(negedge ma_clk);
        checkOutput("t6_req_next", {E_req, S_req, L_req}, 3'b001);
        checkOutput("t6_data_next", data_out, 30'h88);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t6_busy_end", busy, 1'b0);
`else
        exp_q.push_back(EV_DONE);
        @(negedge ma_clk);
        checkOutput("t6_rd_c0", fifo_rd, 1'b1);
        for (int c = 1; c <= 110; c++) begin
            nextCycle();
            @(negedge ma_clk);
            if (c % 10 == 0) checkOutput($sformatf("t6_req_c%0d", c), {E_req, S_req, L_req}, 3'b100);
        end
        nextCycle();
        applyStimulus(3'b100);
        @(negedge ma_clk);
        checkOutput("t6_req_c111", {E_req, S_req, L_req}, 3'b100);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("t6_busy_end", busy, 1'b0);
`endif

        // Wrap-up: every expected event seen, pop count as planned
        nextCycle();
        @(negedge ma_clk);
        nextCycle();
        @(negedge ma_clk);
        checkOutput("sb_drained", exp_q.size(), 0);
`ifdef MC_TIMEOUT_EN
        checkOutput("pop_count", pops, 10);
`else
        checkOutput("pop_count", pops, 9);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
